// File: rtl/tx_pkt_arbiter_pkg.sv
// Shared types and helpers for the TX packet arbiter.
package tx_pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StXfer  = 2'd1,
        StAbort = 2'd2,
        StDrain = 2'd3
    } arb_state_e;

    localparam int unsigned ABORT_CNT_W = 16;
    localparam logic [ABORT_CNT_W-1:0] ABORT_CNT_MAX = 16'hFFFF;

    // Ceiling log2; returns 0 for inputs 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = unsigned'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_pkt_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so the port after 'last' sits at bit 0,
// then take the lowest set bit and map it back to a port number.
module tx_pkt_arbiter_rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned GRANT_W   = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GRANT_W-1:0]   last,
    output logic [GRANT_W-1:0]   grant,
    output logic                 any
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    int unsigned            first;

    // Rotate then priority-encode.
    always_comb begin
        dbl   = {req, req} >> (32'(last) + 32'd1);
        rot   = dbl[NUM_PORTS-1:0];
        first = 0;
        for (int j = int'(NUM_PORTS) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                first = unsigned'(j);
            end
        end
        grant = GRANT_W'((32'(last) + 32'd1 + first) % NUM_PORTS);
        any   = |req;
    end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter onto the single 10G MAC TX stream, with a
// mid-packet stall watchdog that emits an underrun beat and drains the stuck packet.
module tx_pkt_arbiter
    import tx_pkt_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    parameter  int unsigned DATA_W    = 64,
    parameter  int unsigned TIMEOUT   = 256,
    localparam int unsigned KEEP_W    = DATA_W / 8,
    localparam int unsigned GRANT_W   = clog2(NUM_PORTS)
) (
    input  logic                          clk156,
    input  logic                          aresetn,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [KEEP_W-1:0]             m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic [NUM_PORTS-1:0]          port_en,
    output logic                          busy,
    output logic [GRANT_W-1:0]            grant_id,
    output logic [ABORT_CNT_W-1:0]        abort_count
);

    localparam int unsigned IDLE_W = clog2(TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [KEEP_W-1:0] ABORT_KEEP = KEEP_W'(1);

    arb_state_e               state_q, state_d;
    logic [GRANT_W-1:0]       grant_q, grant_d;
    logic [GRANT_W-1:0]       last_grant_q, last_grant_d;
    logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic [ABORT_CNT_W-1:0]   abort_count_q, abort_count_d;

    logic [GRANT_W-1:0]       pick_grant;
    logic                     pick_any;
    logic                     sel_valid;
    logic                     sel_last;

    tx_pkt_arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GRANT_W   (GRANT_W)
    ) u_rr_pick (
        .req   (s_axis_tvalid & port_en),
        .last  (last_grant_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign sel_valid   = s_axis_tvalid[grant_q];
    assign sel_last    = s_axis_tlast[grant_q];
    assign busy        = (state_q != StIdle);
    assign grant_id    = grant_q;
    assign abort_count = abort_count_q;

    // Next-state, watchdog, counter and output mux.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        idle_cnt_d    = idle_cnt_q;
        abort_count_d = abort_count_q;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        unique case (state_q)
            StIdle: begin
                idle_cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                m_axis_tvalid          = sel_valid;
                m_axis_tdata           = s_axis_tdata[32'(grant_q)*DATA_W +: DATA_W];
                m_axis_tkeep           = s_axis_tkeep[32'(grant_q)*KEEP_W +: KEEP_W];
                m_axis_tlast           = sel_last;
                s_axis_tready[grant_q] = m_axis_tready;
                if (sel_valid && m_axis_tready) begin
                    idle_cnt_d = '0;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end else if (!sel_valid) begin
                    // A beat on the firing cycle takes the branch above, so it wins.
                    if (TIMEOUT != 0 && idle_cnt_q == IDLE_MAX) begin
                        idle_cnt_d = '0;
                        state_d    = StAbort;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            StAbort: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                m_axis_tkeep  = ABORT_KEEP;
                if (m_axis_tready) begin
                    if (abort_count_q != ABORT_CNT_MAX) begin
                        abort_count_d = abort_count_q + 16'd1;
                    end
                    state_d = StDrain;
                end
            end
            StDrain: begin
                s_axis_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
        endcase
    end

    // State registers; port 0 wins the first arbitration after reset.
    always_ff @(posedge clk156 or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            last_grant_q  <= GRANT_W'(NUM_PORTS - 1);
            idle_cnt_q    <= '0;
            abort_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            idle_cnt_q    <= idle_cnt_d;
            abort_count_q <= abort_count_d;
        end
    end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Randomized bench for tx_pkt_arbiter against a packet-ownership reference model.
module tb_tx_pkt_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int TMO = 8;
    localparam int NCYC = 3000;

    logic               clk156 = 1'b0;
    logic               aresetn = 1'b0;
    logic [NP*DW-1:0]   s_axis_tdata;
    logic [NP*KW-1:0]   s_axis_tkeep;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP-1:0]      s_axis_tlast;
    logic [NP-1:0]      s_axis_tready;
    logic [DW-1:0]      m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic               m_axis_tuser;
    logic               m_axis_tready;
    logic [NP-1:0]      port_en;
    logic               busy;
    logic [1:0]         grant_id;
    logic [15:0]        abort_count;

    tx_pkt_arbiter #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk156        (clk156),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .port_en       (port_en),
        .busy          (busy),
        .grant_id      (grant_id),
        .abort_count   (abort_count)
    );

    always #5 clk156 = ~clk156;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sources: each port always has a packet; gap = cycles to hold tvalid low.
    int            src_len[NP];
    int            src_beat[NP];
    int            src_gap[NP];
    logic [DW-1:0] src_data[NP];
    logic [KW-1:0] src_keep[NP];

    task automatic new_beat(input int p);
        src_data[p] = {$urandom, $urandom};
        src_keep[p] = KW'($urandom_range(1, 255));
    endtask

    task automatic new_packet(input int p);
        src_len[p]  = $urandom_range(1, 5);
        src_beat[p] = 0;
        src_gap[p]  = $urandom_range(0, 4);
        new_beat(p);
    endtask

    // Mid-packet gaps: mostly none, some short, a few around the watchdog threshold.
    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 31);
        if (r < 20) return 0;
        if (r < 28) return $urandom_range(1, 3);
        return $urandom_range(TMO - 2, TMO + 2);
    endfunction

    task automatic drive_sources();
        for (int p = 0; p < NP; p++) begin
            s_axis_tvalid[p]          = (src_gap[p] == 0);
            s_axis_tlast[p]           = (src_beat[p] == src_len[p] - 1);
            s_axis_tdata[p*DW +: DW]  = src_data[p];
            s_axis_tkeep[p*KW +: KW]  = src_keep[p];
        end
    endtask

    logic [NP-1:0] acc;

    task automatic step_sources();
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                if (src_beat[p] == src_len[p] - 1) begin
                    new_packet(p);
                end else begin
                    src_beat[p]++;
                    src_gap[p] = pick_gap();
                    new_beat(p);
                end
            end else if (src_gap[p] > 0) begin
                src_gap[p]--;
            end
        end
    endtask

    // Reference model: who owns the path, and whether it is aborting or discarding.
    int owner;
    int rr_ptr;
    int cur_id;
    int idle_run;
    bit abort_pend;
    bit discard;
    int aborts;

    logic [NP-1:0] e_rdy;
    logic          e_val, e_last, e_user;
    logic [DW-1:0] e_data;
    logic [KW-1:0] e_keep;

    task automatic model_reset();
        owner      = -1;
        rr_ptr     = NP - 1;
        cur_id     = 0;
        idle_run   = 0;
        abort_pend = 0;
        discard    = 0;
        aborts     = 0;
    endtask

    task automatic model_outputs();
        e_rdy  = '0;
        e_val  = 1'b0;
        e_last = 1'b0;
        e_user = 1'b0;
        e_data = '0;
        e_keep = '0;
        if (owner >= 0) begin
            if (abort_pend) begin
                e_val  = 1'b1;
                e_last = 1'b1;
                e_user = 1'b1;
                e_keep = KW'(1);
            end else if (discard) begin
                e_rdy[owner] = 1'b1;
            end else begin
                e_val        = s_axis_tvalid[owner];
                e_last       = s_axis_tlast[owner];
                e_data       = s_axis_tdata[owner*DW +: DW];
                e_keep       = s_axis_tkeep[owner*KW +: KW];
                e_rdy[owner] = m_axis_tready;
            end
        end
    endtask

    task automatic model_step();
        logic [NP-1:0] req;
        if (owner < 0) begin
            req = s_axis_tvalid & port_en;
            for (int k = 1; k <= NP; k++) begin
                if (owner < 0 && req[(rr_ptr + k) % NP]) begin
                    owner    = (rr_ptr + k) % NP;
                    cur_id   = owner;
                    idle_run = 0;
                end
            end
        end else if (abort_pend) begin
            if (m_axis_tready) begin
                aborts     = (aborts == 65535) ? 65535 : aborts + 1;
                abort_pend = 0;
                discard    = 1;
            end
        end else if (discard) begin
            if (s_axis_tvalid[owner] && s_axis_tlast[owner]) begin
                rr_ptr  = owner;
                owner   = -1;
                discard = 0;
            end
        end else if (s_axis_tvalid[owner]) begin
            if (m_axis_tready) begin
                idle_run = 0;
                if (s_axis_tlast[owner]) begin
                    rr_ptr = owner;
                    owner  = -1;
                end
            end
        end else begin
            idle_run++;
            if (idle_run == TMO) begin
                abort_pend = 1;
                idle_run   = 0;
            end
        end
    endtask

    task automatic compare_cycle();
        model_outputs();
        check_eq("m_tvalid", m_axis_tvalid, e_val);
        check_eq("m_tlast", m_axis_tlast, e_last);
        check_eq("m_tuser", m_axis_tuser, e_user);
        check_eq("m_tdata", m_axis_tdata, e_data);
        check_eq("m_tkeep", m_axis_tkeep, e_keep);
        check_eq("s_tready", s_axis_tready, e_rdy);
        check_eq("rdy_onehot0", $onehot0(s_axis_tready), 1);
        check_eq("busy", busy, (owner >= 0));
        check_eq("grant_id", grant_id, cur_id);
        check_eq("abort_count", abort_count, aborts);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_m_tdata"}, m_axis_tdata, 0);
        check_eq({tag, "_m_tuser"}, {m_axis_tuser, m_axis_tlast, m_axis_tkeep}, 0);
        check_eq({tag, "_s_tready"}, s_axis_tready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_grant_id"}, grant_id, 0);
        check_eq({tag, "_abort_count"}, abort_count, 0);
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        for (int p = 0; p < NP; p++) new_packet(p);
        drive_sources();
        repeat (2) @(posedge clk156);
        #1 aresetn = 1'b1;
    endtask

    initial begin
        m_axis_tready = 1'b1;
        port_en       = 4'hF;
        model_reset();
        for (int p = 0; p < NP; p++) begin
            new_packet(p);
            src_gap[p] = 0;
        end
        drive_sources();
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        check_all_zero("reset");
        @(posedge clk156);
        #1 aresetn = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk156);
            compare_cycle();
            acc = e_rdy & s_axis_tvalid;
            model_step();
            @(posedge clk156);
            #1;
            step_sources();
            drive_sources();
            if (cyc < 1000)      m_axis_tready = 1'b1;
            else if (cyc < 2000) m_axis_tready = cyc[0];
            else                 m_axis_tready = ($urandom_range(0, 3) != 0);
            if (cyc < 500)       port_en = 4'hF;
            else if (cyc < 700)  port_en = 4'b1101;
            else if (cyc < 1000) port_en = 4'b1100;
            else if (cyc % 64 == 0) port_en = NP'($urandom_range(1, 15));
            if (cyc == 1500 || cyc == 2500) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
